// File: rtl/up_counter.sv
// -----------------------------------------------------------------------------
// up_counter
//
// Modulo-MODULUS synchronous up counter with count enable, synchronous clear,
// clamped parallel load and a sticky overflow flag. It counts 0..MODULUS-1.
// It is the ascending counterpart of the 3-bit down counter.
//
// Parameters
//   WIDTH    counter width in bits (default 3)
//   MODULUS  count range 0..MODULUS-1, legal 2 <= MODULUS <= 2**WIDTH (default 8)
//
// Build option
//   UP_COUNTER_SATURATE_EN  when defined, the counter holds at MODULUS-1
//                           instead of wrapping to 0. The default build wraps.
//
// Ports
//   clk       in   1      sole clock, rising edge
//   rst       in   1      asynchronous reset, active low
//   clr       in   1      synchronous clear of count and ovf (highest priority)
//   load      in   1      synchronous load of load_val (clamped to MODULUS-1)
//   load_val  in   WIDTH  value taken on load
//   en        in   1      count enable
//   count     out  WIDTH  registered count value
//   tc        out  1      terminal count, combinational: en & (count == MODULUS-1)
//   ovf       out  1      registered sticky overflow flag
// -----------------------------------------------------------------------------
module up_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Reject parameter sets that cannot be represented at elaboration time.
  generate
    if ((WIDTH < 1) || (MODULUS < 2) ||
        (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_param_check
      $error("up_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             at_max;
  logic [WIDTH-1:0] load_clamped;

  assign at_max = (count_reg == MAX_VAL);

  // Out-of-range load values land on the terminal value so that count can
  // never leave 0..MODULUS-1.
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // One action per edge: clr, then load, then en, otherwise hold.
  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (load) begin
      // Load never touches ovf, even when it coincides with en at the terminal value.
      count_next = load_clamped;
    end else if (en) begin
      if (at_max) begin
`ifdef UP_COUNTER_SATURATE_EN
        count_next = MAX_VAL;
`else
        count_next = '0;
`endif
        ovf_next   = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

  // Combinational so a downstream stage can use it as a cascade enable in
  // the same cycle.
  assign tc    = en & at_max;

endmodule

// File: tb/tb_up_counter.sv
// -----------------------------------------------------------------------------
// tb_up_counter
//
// Drives two counters (MODULUS=8 and MODULUS=6, WIDTH=3) from shared inputs.
// A behavioural model computes the expected count/ovf per instance from the
// counting rules; a compare process checks every instance on each falling
// edge. Directed vectors add literal expectations that pin the model itself.
// Honours UP_COUNTER_SATURATE_EN in the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_up_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       en = 1'b0;

  logic [2:0] count_a, count_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int checks   = 0;
  int failures = 0;

`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  up_counter #(.WIDTH(3), .MODULUS(8)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  up_counter #(.WIDTH(3), .MODULUS(6)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt_a = 0, m_cnt_b = 0;
  bit m_ovf_a = 0, m_ovf_b = 0;

  // Next state of a modulo-m counter from the rules: clear, clamped load,
  // modular (or saturating) increment with a sticky overflow on the top value.
  function automatic void model_step(input int m, inout int cnt, inout bit ov);
    if (clr) begin
      cnt = 0;
      ov  = 0;
    end else if (load) begin
      cnt = (int'(load_val) < m) ? int'(load_val) : m - 1;
    end else if (en) begin
      if (cnt + 1 >= m) ov = 1;
      cnt = SAT ? ((cnt + 1 < m) ? cnt + 1 : m - 1) : (cnt + 1) % m;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt_a = 0; m_ovf_a = 0;
      m_cnt_b = 0; m_ovf_b = 0;
    end else begin
      model_step(8, m_cnt_a, m_ovf_a);
      model_step(6, m_cnt_b, m_ovf_b);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit run = 0;
  always @(negedge clk) begin
    if (run) begin
      check("a.count", int'(count_a), m_cnt_a);
      check("a.ovf",   int'(ovf_a),   int'(m_ovf_a));
      check("a.tc",    int'(tc_a),    int'(en && (m_cnt_a == 7)));
      check("b.count", int'(count_b), m_cnt_b);
      check("b.ovf",   int'(ovf_b),   int'(m_ovf_b));
      check("b.tc",    int'(tc_b),    int'(en && (m_cnt_b == 5)));
      $display("cyc t=%0t clr=%0b load=%0b lv=%0d en=%0b | a=%0d tc=%0b ovf=%0b | b=%0d tc=%0b ovf=%0b",
               $time, clr, load, load_val, en, count_a, tc_a, ovf_a, count_b, tc_b, ovf_b);
    end
  end

  // Apply one set of inputs for one clock edge; returns 1ns after the edge.
  task automatic step(input logic c, input logic l, input logic [2:0] lv, input logic e);
    clr = c; load = l; load_val = lv; en = e;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run = 1;
    check("reset.count", int'(count_a), 0);
    check("reset.ovf",   int'(ovf_a),   0);
    check("reset.tc",    int'(tc_a),    0);
    rst = 1'b1;

    // Count to 5, then assert reset mid-cycle: must clear with no edge.
    repeat (5) step(0, 0, 3'd0, 1);
    check("pre_reset.count", int'(count_a), 5);
    #2 rst = 1'b0;
    #1;
    check("async_reset.count", int'(count_a), 0);
    check("async_reset.ovf",   int'(ovf_a),   0);
    @(posedge clk); #1;
    check("held_in_reset.count", int'(count_a), 0);
    rst = 1'b1;
    step(0, 0, 3'd0, 1); check("release.1", int'(count_a), 1);
    step(0, 0, 3'd0, 1); check("release.2", int'(count_a), 2);
    step(0, 0, 3'd0, 1); check("release.3", int'(count_a), 3);

    // Wrap / saturate from 0 for 10 enabled edges.
    step(1, 0, 3'd0, 0);
    check("clr.count", int'(count_a), 0);
    repeat (7) step(0, 0, 3'd0, 1);
    check("seven.count", int'(count_a), 7);
    check("seven.ovf",   int'(ovf_a),   0);
    step(0, 0, 3'd0, 1);
    check("eighth.count", int'(count_a), SAT ? 7 : 0);
    check("eighth.ovf",   int'(ovf_a),   1);
    repeat (2) step(0, 0, 3'd0, 1);
    check("tenth.a", int'(count_a), SAT ? 7 : 2);
    check("tenth.b", int'(count_b), SAT ? 5 : 4);
    check("tenth.ovf_sticky", int'(ovf_a), 1);

    // Clamped load: 7 fits modulo 8, clamps to 5 modulo 6; ovf survives load.
    step(0, 1, 3'd7, 0);
    check("load7.a",   int'(count_a), 7);
    check("load7.b",   int'(count_b), 5);
    check("load.ovf",  int'(ovf_a),   1);

    // Priority: clr beats load and en.
    step(1, 1, 3'd3, 1);
    check("prio_clr.count", int'(count_a), 0);
    check("prio_clr.ovf",   int'(ovf_a),   0);
    // load beats en.
    step(0, 1, 3'd7, 1);
    check("prio_load.count", int'(count_a), 7);
    check("prio_load.ovf",   int'(ovf_a),   0);
    // tc visible combinationally before the edge.
    en = 1'b1; load = 1'b0; #1;
    check("tc_same_cycle", int'(tc_a), 1);
    step(0, 0, 3'd0, 1);
    check("prio_en.count", int'(count_a), SAT ? 7 : 0);
    check("prio_en.ovf",   int'(ovf_a),   1);

    // Hold at 4 for four idle cycles.
    step(0, 1, 3'd4, 0);
    repeat (4) step(0, 0, 3'd0, 0);
    check("hold.count", int'(count_a), 4);
    check("hold.tc",    int'(tc_a),    0);

    // MODULUS=6 sequence from 0: tc at 5 then back to 0 (or held).
    step(1, 0, 3'd0, 0);
    repeat (5) step(0, 0, 3'd0, 1);
    check("mod6.five", int'(count_b), 5);
    check("mod6.tc",   int'(tc_b),    1);
    step(0, 0, 3'd0, 1);
    check("mod6.after", int'(count_b), SAT ? 5 : 0);
    check("mod6.ovf",   int'(ovf_b),   1);

    step(0, 0, 3'd0, 0);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/up_counter.md
# up_counter

Modulo-N synchronous up counter with enable, synchronous clear and parallel load, counting from 0 toward MODULUS-1. It is the count-up counterpart of the team's 3-bit down counter: same clock domain, and with default parameters it produces the complementary sequence 0,1,…,7,0. It drives sequencing and timing logic that needs an ascending index plus a terminal-count strobe.

## Interface
- WIDTH, 3: counter width in bits.
- MODULUS, 8: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; illegal values are an elaboration error.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear; active high.
- load  input  1  synchronous parallel load; active high.
- load_val  input  WIDTH  value taken on load.
- en  input  1  count enable; active high.
- count  output  WIDTH  registered count value.
- tc  output  1  terminal count; combinational, tc = en & (count == MODULUS-1).
- ovf  output  1  registered sticky overflow flag.

## Operation
- rst low (asynchronous, at any time): count=0 and ovf=0 immediately, with no clock edge required. tc=0 follows from count=0 (MODULUS ≥ 2).
- Each rising clk edge with rst high applies exactly one action, in this priority order:
  - clr=1: count←0; ovf←0.
  - else load=1: count←load_val if load_val ≤ MODULUS-1, else count←MODULUS-1 (clamp). ovf is unchanged.
  - else en=1: count←count+1 when count < MODULUS-1. At count==MODULUS-1 the wrap/saturate rule under Configuration applies, and ovf←1.
  - else: count and ovf hold.
- Arithmetic is unsigned, WIDTH bits. The increment never produces a value ≥ MODULUS, and count never holds a value outside 0..MODULUS-1.
- ovf is sticky. It is cleared only by rst or clr; load does not clear it.
- The block has no internal state beyond count and ovf. No separate FSM exists; the count value is the state.

## Timing
- count and ovf change only on the rising clk edge, except on assertion of the asynchronous reset.
- Latency is 1 cycle from en/load/clr sampled high to the new count value.
- tc is valid in the same cycle en is high with count==MODULUS-1, so downstream logic can use it as a cascade enable with no added latency.
- Simultaneous clr+load+en: clr wins. Simultaneous load+en: load wins, with no increment and no ovf set, even when count==MODULUS-1.
- rst release: first action on the first rising edge after rst goes high. Release must meet recovery time relative to clk; no internal reset synchronizer is provided.
- Reset mid-count: count goes to 0 asynchronously, and the sequence restarts from 0 after release.

## Configuration
- UP_COUNTER_SATURATE_EN
  - Defined: at count==MODULUS-1 with en=1, count holds at MODULUS-1 (saturates), ovf←1, and tc stays high while en=1.
  - Undefined (default): at count==MODULUS-1 with en=1, count←0 (wraps) and ovf←1.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: drive rst=0 mid-cycle with count=5 (WIDTH=3, MODULUS=8) -> count=0 and ovf=0 immediately without a clk edge. Release rst with en=1 -> count 1,2,3 on successive edges.
- Wrap (default build, MODULUS=8): en=1 for 10 cycles from 0 -> count 1..7,0,1,2. tc=1 only in the cycle where count=7. ovf=1 from the edge on which count goes 7→0 and stays 1.
- Non-power-of-two (MODULUS=6): en=1 from 0 -> 0,1,2,3,4,5,0. tc high at 5. load with load_val=7 -> count=5 (clamped).
- Priority: count=7, clr=load=en=1 with load_val=3 -> count=0, ovf=0. Next cycle load=en=1 with load_val=7 -> count=7, ovf=0. Next cycle load=0, en=1 -> count=0, ovf=1.
- Hold: en=0, load=0, clr=0 for 4 cycles at count=4 -> count stays 4, tc=0.
- Saturate build (UP_COUNTER_SATURATE_EN, MODULUS=8): en=1 for 10 cycles from 0 -> count reaches 7 and holds. ovf=1 from the 8th edge. tc=1 in every cycle from count=7 onward.
